fibonacci_stream_checker: RTL and testbench
===========================================

# fibonacci_stream_checker

Consumes a Fibonacci number stream at single rate (one value per beat) or double rate (two values per beat) and checks every value against the recurrence F[n] = F[n-1] + F[n-2] mod 2^W. It is the receiving end of the `fibonacci` / `fibonacci_2` generators. It lets a bench or an on-chip monitor flag corrupted values without keeping a software reference queue. All outputs are registered status; the checker never back-pressures the source.

## Interface
- W, 16: data width of each value
- CNT_W, 16: width of the value counter, error counter and error index
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, asynchronous, active-low; clock clk
- clr  in  1  synchronous clear to the post-reset state; has priority over in_valid
- in_valid  in  1  beat qualifier; one beat per cycle in which it is high
- in_dual  in  1  1: beat carries in_num then in_num2 (two values); 0: in_num only
- in_num  in  W  first (or only) value of the beat
- in_num2  in  W  second value, ignored when in_dual=0
- locked  out  1  two history values held; every further value is checked
- err  out  1  sticky, set by the first mismatch
- err_pulse  out  1  high for one cycle after any beat containing a mismatch
- err_cnt  out  CNT_W  number of mismatching values, saturating
- err_idx  out  CNT_W  zero-based stream index of the first mismatching value
- err_exp  out  W  expected value at the first mismatch
- count  out  CNT_W  values accepted since reset/clr, saturating at all-ones

## Operation
- History registers: a (older) and b (newer). The FSM has 3 states.
  - EMPTY: single beat stores a=in_num and goes to ONE. Dual beat stores a=in_num, b=in_num2 and goes to TRACK.
  - ONE: single beat stores b=in_num and goes to TRACK. Dual beat checks in_num2 against a+in_num, then sets a=in_num, b=in_num2 and goes to TRACK.
  - TRACK: single beat checks in_num against a+b, then sets a=b, b=in_num. Dual beat checks in_num against a+b and in_num2 against b+in_num, then sets a=in_num, b=in_num2. The FSM stays in TRACK.
- History always loads the received values, not the expected ones. A single corrupted value therefore also causes mismatches on the following values; this is intended.
- Sums are truncated to W bits, so the checker follows the generator through overflow.
- count advances by 1 or 2 per beat. Index of in_num = count before the beat; index of in_num2 = count+1.
- On the first mismatch, err_idx and err_exp are captured. If both values of a dual beat mismatch, the in_num mismatch is the one captured. Later mismatches only increment err_cnt, by 1 or 2 per beat.
- Cycles with in_valid=0 change nothing except that err_pulse returns to 0.
- clr and rst: state EMPTY, a=b=0, and every output 0.

## Timing
- Reset values: every output is 0.
- Latency is 1 cycle. Values sampled at posedge k appear on all outputs after posedge k.
- A beat is accepted every cycle at full rate, with no bubbles.
- locked rises after the beat that delivers the second value.
- err_pulse is high for exactly one cycle per mismatching beat. Back-to-back mismatching beats keep it high continuously.
- clr together with in_valid: the beat is discarded.
- rst asserted mid-stream clears immediately, with no clock needed. The first beat after release is treated as stream index 0.
- Counter saturation: count stops incrementing at all-ones while checking continues. err_cnt also saturates at all-ones.

## Configuration
- FIB_CHECKER_SEED_EN defined: the values at stream index 0 and 1 must equal 1. Each that does not is a mismatch with err_exp=1, and the value is still loaded into history.
- Not defined: indices 0 and 1 are accepted unchecked as the seed. Only index ≥2 is checked.

## Test plan
- Reset: hold rst low for 2 cycles with in_valid toggling -> all outputs 0, locked=0.
- Single rate: beats 1,1,2,3,5,8,13,21 -> err=0, locked high after 2nd beat, count=8.
- Double rate: beats (1,1),(2,3),(5,8),(13,21) -> err=0, locked after 1st beat, count=8.
- Error injection:
  - Stream: single 1, dual (1,2), single 4, single 6, single 10.
  - Response: err_idx=3, err_exp=3, err_cnt=1; 6 and 10 pass.
  - err_pulse high one cycle, exactly after the 4 beat.
- Wrap and seed: W=16, single beats 40000, 30000, 4464 -> no error (70000 mod 65536).
  - With FIB_CHECKER_SEED_EN, the same stream gives err=1, err_idx=0, err_exp=1, err_cnt=2.
- clr mid-stream: after the beats 1,1,2, assert clr together with a valid beat of 99 -> all outputs 0 and 99 dropped.
  - Then single beats 5,7,12 -> no error, count=3.

Source files
------------

// File: rtl/fibonacci_stream_checker_if.sv
// -----------------------------------------------------------------------------
// fibonacci_stream_checker_if
//
// Groups the stream input and the registered status of the Fibonacci stream
// checker into one bundle.
//
// Parameters
//   W      data width of each stream value
//   CNT_W  width of the value counter, error counter and error index
//
// Signals
//   clr        synchronous clear, priority over in_valid
//   in_valid   beat qualifier, one beat per cycle in which it is high
//   in_dual    1: beat carries in_num then in_num2, 0: in_num only
//   in_num     first (or only) value of the beat
//   in_num2    second value of a dual beat
//   locked     two history values held, every further value is checked
//   err        sticky first-mismatch flag
//   err_pulse  one-cycle flag after a beat containing a mismatch
//   err_cnt    saturating count of mismatching values
//   err_idx    stream index of the first mismatching value
//   err_exp    expected value at the first mismatch
//   count      saturating count of accepted values
//   dbg_state  checker FSM state (0 EMPTY, 1 ONE, 2 TRACK)
//
// Handshake: the source presents a beat by raising in_valid for one cycle per
// beat. There is no ready; the checker accepts every beat it sees, so a beat
// is consumed on every posedge clk at which in_valid=1 and clr=0.
//
// Modports
//   master  the stream source / observer (drives inputs, reads status)
//   slave   the checker
// -----------------------------------------------------------------------------
interface fibonacci_stream_checker_if #(
    parameter int W     = 16,
    parameter int CNT_W = 16
);
    logic             clr;
    logic             in_valid;
    logic             in_dual;
    logic [W-1:0]     in_num;
    logic [W-1:0]     in_num2;
    logic             locked;
    logic             err;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] err_idx;
    logic [W-1:0]     err_exp;
    logic [CNT_W-1:0] count;
    logic [1:0]       dbg_state;

    modport master (
        output clr, in_valid, in_dual, in_num, in_num2,
        input  locked, err, err_pulse, err_cnt, err_idx, err_exp, count,
               dbg_state
    );

    modport slave (
        input  clr, in_valid, in_dual, in_num, in_num2,
        output locked, err, err_pulse, err_cnt, err_idx, err_exp, count,
               dbg_state
    );
endinterface

// File: rtl/fibonacci_stream_checker.sv
// -----------------------------------------------------------------------------
// fibonacci_stream_checker
//
// Receives a Fibonacci stream at one or two values per beat and checks each
// value against F[n] = F[n-1] + F[n-2] mod 2^W. All status outputs are
// registered; the source is never back-pressured.
//
// Ports
//   clk  clock, all state updates on posedge
//   rst  asynchronous, active-low reset
//   bus  fibonacci_stream_checker_if.slave (stream inputs, status outputs)
//
// Build option
//   FIB_CHECKER_SEED_EN  when defined, the values at stream index 0 and 1 must
//                        both equal 1 (err_exp=1 on mismatch). When undefined
//                        they are taken unchecked as the seed.
// -----------------------------------------------------------------------------
module fibonacci_stream_checker #(
    parameter int W     = 16,
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    fibonacci_stream_checker_if.slave   bus
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TRACK = 2'd2
    } state_t;

    localparam logic [W-1:0]     VAL_ONE  = W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W:0]   INC_ZERO = '0;
    localparam logic [CNT_W:0]   INC_ONE  = (CNT_W+1)'(1);
    localparam logic [CNT_W:0]   INC_TWO  = (CNT_W+1)'(2);

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] err_idx_q, err_idx_d;
    logic [W-1:0]     err_exp_q, err_exp_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Per-value check controls for the current beat
    logic             chk0, chk1;
    logic [W-1:0]     exp0, exp1;
    logic             mis0, mis1;
    logic [CNT_W:0]   cnt_inc, cnt_sum;
    logic [CNT_W:0]   ecnt_inc, ecnt_sum;

    // Expected values depend only on history and the first value of the beat,
    // so they are formed unconditionally and gated by in_valid below.
    always_comb begin
        chk0 = 1'b0;
        chk1 = 1'b0;
        exp0 = '0;
        exp1 = '0;
        unique case (state_q)
            S_EMPTY: begin
`ifdef FIB_CHECKER_SEED_EN
                chk0 = 1'b1;
                exp0 = VAL_ONE;
                chk1 = bus.in_dual;
                exp1 = VAL_ONE;
`endif
            end
            S_ONE: begin
`ifdef FIB_CHECKER_SEED_EN
                chk0 = 1'b1;
                exp0 = VAL_ONE;
`endif
                chk1 = bus.in_dual;
                exp1 = a_q + bus.in_num;
            end
            S_TRACK: begin
                chk0 = 1'b1;
                exp0 = a_q + b_q;
                chk1 = bus.in_dual;
                // Second value follows the received first value, not exp0
                exp1 = b_q + bus.in_num;
            end
            default: begin
                chk0 = 1'b0;
                chk1 = 1'b0;
            end
        endcase
        mis0 = chk0 && (bus.in_num != exp0);
        mis1 = chk1 && (bus.in_num2 != exp1);
    end

    // Saturating increments for count and err_cnt (one spare carry bit)
    always_comb begin
        cnt_inc  = bus.in_dual ? INC_TWO : INC_ONE;
        cnt_sum  = {1'b0, count_q} + cnt_inc;
        ecnt_inc = (mis0 && mis1) ? INC_TWO :
                   (mis0 || mis1) ? INC_ONE : INC_ZERO;
        ecnt_sum = {1'b0, err_cnt_q} + ecnt_inc;
    end

    // Next-state and status logic
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        locked_d    = locked_q;
        err_d       = err_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        err_idx_d   = err_idx_q;
        err_exp_d   = err_exp_q;
        count_d     = count_q;

        if (bus.clr) begin
            state_d   = S_EMPTY;
            a_d       = '0;
            b_d       = '0;
            locked_d  = 1'b0;
            err_d     = 1'b0;
            err_cnt_d = '0;
            err_idx_d = '0;
            err_exp_d = '0;
            count_d   = '0;
        end else if (bus.in_valid) begin
            // History always takes the received values
            unique case (state_q)
                S_EMPTY: begin
                    a_d = bus.in_num;
                    if (bus.in_dual) begin
                        b_d     = bus.in_num2;
                        state_d = S_TRACK;
                    end else begin
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (bus.in_dual) begin
                        a_d = bus.in_num;
                        b_d = bus.in_num2;
                    end else begin
                        b_d = bus.in_num;
                    end
                    state_d = S_TRACK;
                end
                S_TRACK: begin
                    if (bus.in_dual) begin
                        a_d = bus.in_num;
                        b_d = bus.in_num2;
                    end else begin
                        a_d = b_q;
                        b_d = bus.in_num;
                    end
                end
                default: state_d = S_EMPTY;
            endcase

            locked_d = (state_d == S_TRACK);
            count_d  = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

            if (mis0 || mis1) begin
                err_pulse_d = 1'b1;
                err_cnt_d   = ecnt_sum[CNT_W] ? '1 : ecnt_sum[CNT_W-1:0];
                if (!err_q) begin
                    // in_num wins when both values of a dual beat are wrong
                    err_d     = 1'b1;
                    err_idx_d = mis0 ? count_q : (count_q + CNT_ONE);
                    err_exp_d = mis0 ? exp0 : exp1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_EMPTY;
            a_q         <= '0;
            b_q         <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            err_idx_q   <= '0;
            err_exp_q   <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            err_idx_q   <= err_idx_d;
            err_exp_q   <= err_exp_d;
            count_q     <= count_d;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err       = err_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.err_idx   = err_idx_q;
    assign bus.err_exp   = err_exp_q;
    assign bus.count     = count_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_fibonacci_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_fibonacci_stream_checker
//
// Bench for fibonacci_stream_checker. Counters use a narrow CNT_W so that
// saturation is reached in a short run. Honours FIB_CHECKER_SEED_EN.
// -----------------------------------------------------------------------------
module tb_fibonacci_stream_checker;

    localparam int W     = 16;
    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic             locked;
        logic             err;
        logic             err_pulse;
        logic [CNT_W-1:0] err_cnt;
        logic [CNT_W-1:0] err_idx;
        logic [W-1:0]     err_exp;
        logic [CNT_W-1:0] count;
    } exp_t;

    logic clk;
    logic rst;

    fibonacci_stream_checker_if #(.W(W), .CNT_W(CNT_W)) bus ();

    fibonacci_stream_checker #(.W(W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: act=%0d req=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expected snapshot per driven clock, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("locked",    bus.locked,    e.locked);
                chk("err",       bus.err,       e.err);
                chk("err_pulse", bus.err_pulse, e.err_pulse);
                chk("err_cnt",   bus.err_cnt,   e.err_cnt);
                chk("err_idx",   bus.err_idx,   e.err_idx);
                chk("err_exp",   bus.err_exp,   e.err_exp);
                chk("count",     bus.count,     e.count);
            end
        end
    end

    // ---------------- reference model ----------------
    // Keeps the last received values and derives every expectation from the
    // recurrence and the stream position.
    logic [W-1:0]     hist[$];
    int               m_len;
    int               m_count;
    int               m_err_cnt;
    logic             m_err;
    logic             m_pulse;
    logic [CNT_W-1:0] m_idx;
    logic [W-1:0]     m_exp;
    int               m_nm;

    task automatic model_reset();
        hist.delete();
        m_len     = 0;
        m_count   = 0;
        m_err_cnt = 0;
        m_err     = 1'b0;
        m_pulse   = 1'b0;
        m_idx     = '0;
        m_exp     = '0;
    endtask

    task automatic model_value(input logic [W-1:0] v, input logic [CNT_W-1:0] idx);
        logic [W-1:0] e;
        logic         checked;
        checked = 1'b0;
        e       = '0;
        if (m_len >= 2) begin
            e       = hist[hist.size()-1] + hist[hist.size()-2];
            checked = 1'b1;
        end else begin
`ifdef FIB_CHECKER_SEED_EN
            e       = 1;
            checked = 1'b1;
`endif
        end
        if (checked && v != e) begin
            m_nm++;
            if (!m_err) begin
                m_err = 1'b1;
                m_idx = idx;
                m_exp = e;
            end
        end
        hist.push_back(v);
        if (hist.size() > 2) void'(hist.pop_front());
        m_len++;
    endtask

    task automatic model_beat(input logic dual, input logic [W-1:0] n1, input logic [W-1:0] n2);
        logic [CNT_W-1:0] i0, i1;
        i0   = CNT_W'(m_count);
        i1   = i0 + 1'b1;
        m_nm = 0;
        model_value(n1, i0);
        if (dual) model_value(n2, i1);
        m_count   = (m_count + (dual ? 2 : 1) > MAXC) ? MAXC : m_count + (dual ? 2 : 1);
        m_err_cnt = (m_err_cnt + m_nm > MAXC) ? MAXC : m_err_cnt + m_nm;
        m_pulse   = (m_nm > 0);
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.locked    = (m_len >= 2);
        e.err       = m_err;
        e.err_pulse = m_pulse;
        e.err_cnt   = CNT_W'(m_err_cnt);
        e.err_idx   = m_idx;
        e.err_exp   = m_exp;
        e.count     = CNT_W'(m_count);
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after posedge; the model advances for the
    // inputs sampled at that posedge.
    task automatic do_cycle(input logic v, input logic d, input logic [W-1:0] n1,
                            input logic [W-1:0] n2, input logic c);
        bus.in_valid = v;
        bus.in_dual  = d;
        bus.in_num   = n1;
        bus.in_num2  = n2;
        bus.clr      = c;
        @(posedge clk);
        #1;
        if (!rst || c) model_reset();
        else if (v) model_beat(d, n1, n2);
        else m_pulse = 1'b0;
        exp_q.push_back(snapshot());
        bus.in_valid = 1'b0;
        bus.clr      = 1'b0;
    endtask

    task automatic single(input logic [W-1:0] n);
        do_cycle(1'b1, 1'b0, n, '0, 1'b0);
    endtask

    task automatic dual(input logic [W-1:0] n1, input logic [W-1:0] n2);
        do_cycle(1'b1, 1'b1, n1, n2, 1'b0);
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic clear();
        do_cycle(1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Next correct value given the model history and an optional first value
    function automatic logic [W-1:0] next_good();
        if (hist.size() >= 2) return hist[hist.size()-1] + hist[hist.size()-2];
        return W'($urandom_range(0, 3));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] n1, n2, last;
        int r;
        rst          = 1'b0;
        bus.clr      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_dual  = 1'b0;
        bus.in_num   = '0;
        bus.in_num2  = '0;
        model_reset();

        // Reset held with in_valid toggling
        do_cycle(1'b1, 1'b0, 16'd1, '0, 1'b0);
        do_cycle(1'b0, 1'b0, 16'd1, '0, 1'b0);
        do_cycle(1'b1, 1'b1, 16'd1, 16'd1, 1'b0);
        settle();
        chk("reset_count", bus.count, 0);
        chk("reset_locked", bus.locked, 0);
        rst = 1'b1;
        idle();

        // Single rate
        single(1); single(1); single(2); single(3);
        single(5); single(8); single(13); single(21);
        settle();
        chk("single_count", bus.count, 8);
        chk("single_err", bus.err, 0);
        chk("single_locked", bus.locked, 1);

        // Double rate
        clear();
        dual(1, 1); dual(2, 3); dual(5, 8); dual(13, 21);
        settle();
        chk("dual_count", bus.count, 8);
        chk("dual_err", bus.err, 0);

        // Error injection
        clear();
        single(1); dual(1, 2); single(4); single(6); single(10);
        idle();
        settle();
        chk("inj_err_idx", bus.err_idx, 3);
        chk("inj_err_exp", bus.err_exp, 3);
        chk("inj_err_cnt", bus.err_cnt, 1);
        chk("inj_pulse_gone", bus.err_pulse, 0);

        // Wrap and seed
        clear();
        single(40000); single(30000); single(4464);
        settle();
`ifdef FIB_CHECKER_SEED_EN
        chk("wrap_err", bus.err, 1);
        chk("wrap_err_idx", bus.err_idx, 0);
        chk("wrap_err_exp", bus.err_exp, 1);
        chk("wrap_err_cnt", bus.err_cnt, 2);
`else
        chk("wrap_err", bus.err, 0);
        chk("wrap_count", bus.count, 3);
`endif

        // clr mid-stream with a valid beat
        clear();
        single(1); single(1); single(2);
        do_cycle(1'b1, 1'b0, 16'd99, '0, 1'b1);
        settle();
        chk("clr_count", bus.count, 0);
        chk("clr_locked", bus.locked, 0);
        single(5); single(7); single(12);
        settle();
        chk("clr_then_count", bus.count, 3);
`ifndef FIB_CHECKER_SEED_EN
        chk("clr_then_err", bus.err, 0);
`endif

        // Asynchronous reset mid-stream
        single(19);
        settle();
        rst = 1'b0;
        #2;
        chk("async_rst_count", bus.count, 0);
        chk("async_rst_err", bus.err, 0);
        chk("async_rst_locked", bus.locked, 0);
        model_reset();
        idle();
        rst = 1'b1;

        // Randomized stream with occasional corruption, idles and clears
        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                clear();
            end else if (r < 18) begin
                idle();
            end else begin
                n1 = next_good();
                if ($urandom_range(0, 15) == 0) n1 = n1 ^ W'($urandom_range(1, 65535));
                if (hist.size() >= 1) last = hist[hist.size()-1];
                else last = W'($urandom_range(0, 3));
                n2 = last + n1;
                if ($urandom_range(0, 15) == 0) n2 = n2 ^ W'($urandom_range(1, 65535));
                do_cycle(1'b1, r[0], n1, n2, 1'b0);
            end
        end

        // Saturation of count and err_cnt with random (mostly wrong) values
        clear();
        for (int k = 0; k < 150; k++) begin
            dual(W'($urandom), W'($urandom));
        end
        settle();
        chk("sat_count", bus.count, MAXC);

        idle();
        idle();
        settle();
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
